// File: rtl/rou_mng_agent.sv
// rou_mng_agent: roubus per-node management agent. It handles reset, enumerate,
// control and report messages for this node and forwards everything else through one registered stage.
module rou_mng_agent #(
    parameter int unsigned DWID = 128,
    parameter int unsigned AWID = 32,
    parameter int unsigned TWID = 5,
    parameter int unsigned BWID = (DWID == 512) ? 6 :
                                  (DWID == 256) ? 5 :
                                  (DWID == 128) ? 4 :
                                  (DWID == 64)  ? 3 : 2,
    parameter int unsigned WID  = 2 + DWID + AWID + BWID + TWID
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WID-1:0] in_msg,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [WID-1:0] out_msg,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic [31:0]    status,
    output logic [7:0]     node_id,
    output logic           enumerated,
    output logic [31:0]    control,
    output logic           soft_reset,
    output logic [7:0]     bad_count
);

    localparam int unsigned ALSB = DWID;
    localparam int unsigned TLSB = DWID + AWID + BWID;

    localparam logic [1:0]      CMD_MNG    = 2'b11;
    localparam logic [TWID-1:0] TAG_RESET  = TWID'(0);
    localparam logic [TWID-1:0] TAG_ENUM   = TWID'(2);
    localparam logic [TWID-1:0] TAG_CTRL   = TWID'(4);
    localparam logic [TWID-1:0] TAG_ACK    = TWID'(5);
    localparam logic [TWID-1:0] TAG_REPORT = TWID'(6);
    localparam logic [TWID-1:0] TAG_RESP   = TWID'(7);
    localparam logic [BWID-1:0] RESP_BYTES = BWID'(4);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [1:0]      in_cmd;
    logic [TWID-1:0] in_tag;
    logic [7:0]      in_addr;
    logic [31:0]     in_data_w;
    logic            acc;
    logic            addr_hit;
    logic [WID-1:0]  res_msg;
    logic            do_reset;
    logic            do_enum;
    logic            do_ctrl;
    logic            do_bad;

    assign in_cmd    = in_msg[WID-1 -: 2];
    assign in_tag    = in_msg[TLSB +: TWID];
    assign in_addr   = in_msg[ALSB +: 8];
    assign in_data_w = in_msg[31:0];

    // No skid buffer: a full stage only takes a new message when it drains the same cycle.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign acc       = in_valid && in_ready;
    assign addr_hit  = enumerated && (in_addr == node_id);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (acc) state_d = FULL;
            FULL:  if (out_ready && !acc) state_d = EMPTY;
        endcase
    end

    // Message decode: outgoing message and register side effects for an accepted input
    always_comb begin
        res_msg  = in_msg;
        do_reset = 1'b0;
        do_enum  = 1'b0;
        do_ctrl  = 1'b0;
        do_bad   = 1'b0;
        if (in_cmd == CMD_MNG) begin
            case (in_tag)
                TAG_RESET: do_reset = 1'b1;
                TAG_ENUM: begin
                    if (!enumerated) begin
                        do_enum      = 1'b1;
                        res_msg[7:0] = in_data_w[7:0] + 8'd1;
                    end
                end
                TAG_CTRL: begin
                    if (addr_hit) begin
                        do_ctrl = 1'b1;
                        res_msg = {CMD_MNG, TAG_ACK, BWID'(0), AWID'(node_id), DWID'(0)};
                    end
                end
                TAG_REPORT: begin
                    if (addr_hit) begin
                        res_msg = {CMD_MNG, TAG_RESP, RESP_BYTES, AWID'(node_id), DWID'(status)};
                    end
                end
                // Odd tags are responses from other nodes; other even tags are unknown requests.
                default: do_bad = !in_tag[0];
            endcase
        end
    end

    // Output message register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_msg <= '0;
        end else if (acc) begin
            out_msg <= res_msg;
        end
    end

    // Node management registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_id    <= 8'd0;
            enumerated <= 1'b0;
            control    <= 32'd0;
            soft_reset <= 1'b0;
            bad_count  <= 8'd0;
        end else begin
            soft_reset <= acc && do_reset;
            if (acc) begin
                if (do_reset) begin
                    node_id    <= 8'd0;
                    enumerated <= 1'b0;
                    control    <= 32'd0;
                end
                if (do_enum) begin
                    node_id    <= in_data_w[7:0];
                    enumerated <= 1'b1;
                end
                if (do_ctrl) begin
                    control <= in_data_w;
                end
                if (do_bad && (bad_count != 8'hFF)) begin
                    bad_count <= bad_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rou_mng_agent.sv
// Bench for rou_mng_agent: directed and random traffic compared against a
// transaction-level model of the node state plus a queue of expected output messages.
module tb_rou_mng_agent;

    localparam int unsigned DWID = 128;
    localparam int unsigned AWID = 32;
    localparam int unsigned TWID = 5;
    localparam int unsigned BWID = 4;
    localparam int unsigned WID  = 2 + DWID + AWID + BWID + TWID;

    typedef logic [WID-1:0] msg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    msg_t        in_msg = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    msg_t        out_msg;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] status = 32'd0;
    logic [7:0]  node_id;
    logic        enumerated;
    logic [31:0] control;
    logic        soft_reset;
    logic [7:0]  bad_count;

    rou_mng_agent #(.DWID(DWID), .AWID(AWID), .TWID(TWID)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_msg     (in_msg),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_msg    (out_msg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .status     (status),
        .node_id    (node_id),
        .enumerated (enumerated),
        .control    (control),
        .soft_reset (soft_reset),
        .bad_count  (bad_count)
    );

    always #5 clk = ~clk;

    // Reference model: node state and messages expected at the output, oldest first
    msg_t        exp_q[$];
    logic [7:0]  m_node = 8'd0;
    logic        m_enum = 1'b0;
    logic [31:0] m_ctrl = 32'd0;
    logic [7:0]  m_bad  = 8'd0;
    logic        m_soft = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic msg_t mk(input logic [1:0] c, input logic [4:0] t, input logic [3:0] b,
                                input logic [31:0] a, input logic [127:0] d);
        return {c, t, b, a, d};
    endfunction

    // Apply the message rules to one accepted message
    task automatic apply(input msg_t m, input logic [31:0] st);
        logic [1:0]   c;
        logic [4:0]   t;
        logic [3:0]   b;
        logic [31:0]  a;
        logic [127:0] d;
        msg_t         r;
        logic         hit;
        r = m;
        {c, t, b, a, d} = m;
        hit = m_enum && (a[7:0] == m_node);
        if (c == 2'b11) begin
            if (t == 5'd0) begin
                m_enum = 1'b0;
                m_node = 8'd0;
                m_ctrl = 32'd0;
                m_soft = 1'b1;
            end else if (t == 5'd2) begin
                if (!m_enum) begin
                    m_node = d[7:0];
                    m_enum = 1'b1;
                    d[7:0] = d[7:0] + 8'd1;
                    r = {c, t, b, a, d};
                end
            end else if (t == 5'd4 && hit) begin
                m_ctrl = d[31:0];
                r = mk(2'b11, 5'd5, 4'd0, {24'd0, m_node}, 128'd0);
            end else if (t == 5'd6 && hit) begin
                r = mk(2'b11, 5'd7, 4'd4, {24'd0, m_node}, {96'd0, st});
            end else if (!t[0] && t != 5'd4 && t != 5'd6) begin
                if (m_bad != 8'hFF) m_bad = m_bad + 8'd1;
            end
        end
        exp_q.push_back(r);
    endtask

    task automatic check_outputs();
        check("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("out_msg", 256'(out_msg), 256'(exp_q[0]));
        check("node_id", 256'(node_id), 256'(m_node));
        check("enumerated", 256'(enumerated), 256'(m_enum));
        check("control", 256'(control), 256'(m_ctrl));
        check("bad_count", 256'(bad_count), 256'(m_bad));
        check("soft_reset", 256'(soft_reset), 256'(m_soft));
    endtask

    // One clock cycle; called and returns at a falling edge
    task automatic step(input logic iv, input msg_t m, input logic ordy, input logic [31:0] st);
        logic exp_rdy;
        check_outputs();
        in_valid  = iv;
        in_msg    = m;
        out_ready = ordy;
        status    = st;
        #1;
        exp_rdy = (exp_q.size() == 0) || ordy;
        check("in_ready", 256'(in_ready), 256'(exp_rdy));
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        m_soft = 1'b0;
        if (iv && exp_rdy) apply(m, st);
        @(negedge clk);
    endtask

    task automatic hard_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_msg    = '0;
        status    = 32'd0;
        exp_q.delete();
        m_node = 8'd0;
        m_enum = 1'b0;
        m_ctrl = 32'd0;
        m_bad  = 8'd0;
        m_soft = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 256'(in_ready), 256'(1'b1));
        @(negedge clk);
    endtask

    task automatic rand_msg(output msg_t m);
        logic [1:0]   c;
        logic [4:0]   t;
        logic [3:0]   b;
        logic [31:0]  a;
        logic [127:0] d;
        c = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
        case ($urandom_range(0, 9))
            0:       t = 5'd0;
            1, 2:    t = 5'd2;
            3, 4:    t = 5'd4;
            5, 6:    t = 5'd6;
            7:       t = 5'd8;
            default: t = 5'($urandom);
        endcase
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[7:0] = m_node;
        d = {$urandom, $urandom, $urandom, $urandom};
        b = 4'($urandom);
        m = mk(c, t, b, a, d);
    endtask

    initial begin
        msg_t m;
        msg_t ma;
        msg_t mb;
        msg_t mc;
        msg_t md;

        hard_reset();
        step(1'b0, '0, 1'b1, 32'd0);

        // Enumerate a fresh node with id 5, then a second enumerate is ignored
        step(1'b1, mk(2'b11, 5'd2, 4'd0, 32'd0, 128'h05), 1'b1, 32'd0);
        check("enum_node", 256'(node_id), 256'(8'h05));
        check("enum_flag", 256'(enumerated), 256'(1'b1));
        check("enum_data", 256'(out_msg[7:0]), 256'(8'h06));
        m = mk(2'b11, 5'd2, 4'd0, 32'd0, 128'h09);
        step(1'b1, m, 1'b1, 32'd0);
        check("enum2_node", 256'(node_id), 256'(8'h05));
        check("enum2_fwd", 256'(out_msg), 256'(m));

        // Control addressed to this node, then to another node
        step(1'b1, mk(2'b11, 5'd4, 4'd4, 32'd5, 128'hDEADBEEF), 1'b1, 32'd0);
        check("ctrl_reg", 256'(control), 256'(32'hDEADBEEF));
        check("ctrl_ack", 256'(out_msg), 256'(mk(2'b11, 5'd5, 4'd0, 32'd5, 128'd0)));
        m = mk(2'b11, 5'd4, 4'd4, 32'h1234_5606, 128'h1111_2222);
        step(1'b1, m, 1'b1, 32'd0);
        check("ctrl_miss_fwd", 256'(out_msg), 256'(m));
        check("ctrl_miss_reg", 256'(control), 256'(32'hDEADBEEF));

        // Report addressed to this node
        step(1'b1, mk(2'b11, 5'd6, 4'd0, 32'd5, 128'hFFFF_0000_FFFF), 1'b1, 32'h1234);
        check("rpt_resp", 256'(out_msg), 256'(mk(2'b11, 5'd7, 4'd4, 32'd5, 128'h1234)));

        // Backpressure: output held for 3 cycles, then drained back to back
        ma = mk(2'b00, 5'd3, 4'd1, 32'hA, 128'hAAAA);
        mb = mk(2'b01, 5'd6, 4'd2, 32'hB, 128'hBBBB);
        mc = mk(2'b10, 5'd0, 4'd3, 32'hC, 128'hCCCC);
        md = mk(2'b00, 5'd9, 4'd4, 32'hD, 128'hDDDD);
        step(1'b1, ma, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mb, 1'b0, 32'd0);
            check("bp_hold", 256'(out_msg), 256'(ma));
        end
        step(1'b1, mb, 1'b1, 32'd0);
        check("bp_b", 256'(out_msg), 256'(mb));
        step(1'b1, mc, 1'b1, 32'd0);
        step(1'b1, md, 1'b1, 32'd0);
        check("bp_d", 256'(out_msg), 256'(md));
        step(1'b0, '0, 1'b1, 32'd0);

        // Reset message on an enumerated node; a control in the very next cycle is not for us
        m = mk(2'b11, 5'd0, 4'd0, 32'd5, 128'h77);
        step(1'b1, m, 1'b1, 32'd0);
        check("srst_pulse", 256'(soft_reset), 256'(1'b1));
        check("srst_enum", 256'(enumerated), 256'(1'b0));
        check("srst_ctrl", 256'(control), 256'(32'd0));
        check("srst_fwd", 256'(out_msg), 256'(m));
        m = mk(2'b11, 5'd4, 4'd4, 32'd0, 128'h55);
        step(1'b1, m, 1'b1, 32'd0);
        check("srst_once", 256'(soft_reset), 256'(1'b0));
        check("ctrl_unenum_fwd", 256'(out_msg), 256'(m));

        // Report on a non-enumerated node is forwarded
        m = mk(2'b11, 5'd6, 4'd0, 32'd0, 128'h66);
        step(1'b1, m, 1'b1, 32'h1234);
        check("rpt_unenum_fwd", 256'(out_msg), 256'(m));

        // Enumerate with id 8'hFF wraps the forwarded count to zero
        step(1'b1, mk(2'b11, 5'd2, 4'd0, 32'd0, 128'hFF), 1'b1, 32'd0);
        check("ff_node", 256'(node_id), 256'(8'hFF));
        check("ff_data", 256'(out_msg[7:0]), 256'(8'h00));
        step(1'b0, '0, 1'b1, 32'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 2000; i++) begin
            rand_msg(m);
            step($urandom_range(0, 3) != 0, m, $urandom_range(0, 3) != 0, $urandom);
        end
        step(1'b0, '0, 1'b1, 32'd0);

        // Unknown request counter saturates
        hard_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, mk(2'b11, 5'd8, 4'd0, $urandom, 128'd0), 1'b1, 32'd0);
        end
        check("bad_sat", 256'(bad_count), 256'(8'hFF));
        step(1'b0, '0, 1'b1, 32'd0);

        // Asynchronous reset while the output is full
        step(1'b1, mk(2'b00, 5'd1, 4'd0, 32'h5, 128'h123), 1'b0, 32'd0);
        check("arst_pre", 256'(out_valid), 256'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 256'(out_valid), 256'(1'b0));
        check("arst_msg", 256'(out_msg), 256'(0));
        hard_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, mk(2'b00, 5'd2, 4'd0, $urandom, 128'h9), 1'b1, 32'd0);
        end
        step(1'b0, '0, 1'b1, 32'd0);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
